// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified memory port arbiter:
// state encodings, full-word byte enable and a byte-enable helper.
package mem_arbiter_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_BUSY_I = 3'd1;
  localparam logic [2:0] ST_BUSY_D = 3'd2;
  localparam logic [2:0] ST_DONE_I = 3'd3;
  localparam logic [2:0] ST_DONE_D = 3'd4;

  localparam logic [3:0] BE_WORD = 4'b1111;

  // Reads always fetch the whole word.
  function automatic logic [3:0] cmd_be(
    input logic       we,
    input logic [3:0] be
  );
    return we ? be : BE_WORD;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr2.sv
// Two-way round-robin grant between fetch (i) and data (d).
// Ports: req_i/req_d in, upd/served_d update last_d, grant_i/grant_d out.
module mem_arbiter_rr2 (
  input  logic clk,
  input  logic reset,
  input  logic req_i,
  input  logic req_d,
  input  logic upd,
  input  logic served_d,
  output logic grant_i,
  output logic grant_d
);

  logic last_d;

  always_ff @(posedge clk) begin
    if (reset)
      last_d <= 1'b0;
    else if (upd)
      last_d <= served_d;
  end

  // Data wins a conflict unless it was served last.
  assign grant_d = req_d & (~req_i | ~last_d);
  assign grant_i = req_i & ~grant_d;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch (F) and the M-stage data access.
// Ports: F/M request sides with stalls, mem_* memory side, bus_error.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CW      = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_req_F,
  input  logic [31:0] instr_addr_F,
  output logic [31:0] instr_rdata_F,
  output logic        instr_stall_F,
  input  logic        data_req_M,
  input  logic        mem_write_M,
  input  logic [31:0] data_addr_M,
  input  logic [31:0] mem_in_M,
  input  logic [3:0]  byte_en_M,
  output logic [31:0] mem_out_M,
  output logic        data_stall_M,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        bus_error
);

  logic [2:0]    state, state_n;
  logic [CW-1:0] cnt;
  logic          grant_i, grant_d;
  logic          busy, grab, timeout, finish;
  logic          we_q;
  logic [31:0]   addr_q, wdata_q;
  logic [3:0]    be_q;
  logic [31:0]   rd;

  assign busy    = (state == ST_BUSY_I) | (state == ST_BUSY_D);
  assign grab    = (state == ST_IDLE) & (grant_i | grant_d);
  assign timeout = busy & ~mem_ready & (cnt == CW'(TIMEOUT - 1));
  assign finish  = busy & (mem_ready | timeout);
  assign rd      = timeout ? 32'd0 : mem_rdata;

  mem_arbiter_rr2 u_rr2 (
    .clk      (clk),
    .reset    (reset),
    .req_i    (instr_req_F),
    .req_d    (data_req_M),
    .upd      (finish),
    .served_d (state == ST_BUSY_D),
    .grant_i  (grant_i),
    .grant_d  (grant_d)
  );

  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: begin
        if (grant_d)
          state_n = ST_BUSY_D;
        else if (grant_i)
          state_n = ST_BUSY_I;
      end
      ST_BUSY_I: if (finish) state_n = ST_DONE_I;
      ST_BUSY_D: if (finish) state_n = ST_DONE_D;
      ST_DONE_I: state_n = ST_IDLE;
      ST_DONE_D: state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req       = busy;
    mem_we        = busy & we_q;
    mem_addr      = addr_q;
    mem_wdata     = wdata_q;
    mem_be        = be_q;
    instr_stall_F = instr_req_F & (state != ST_DONE_I);
    data_stall_M  = data_req_M & (state != ST_DONE_D);
  end

  // Captured command, held for the whole transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (grab) begin
      if (grant_d) begin
        we_q    <= mem_write_M;
        addr_q  <= data_addr_M;
        wdata_q <= mem_in_M;
        be_q    <= cmd_be(mem_write_M, byte_en_M);
      end else begin
        we_q    <= 1'b0;
        addr_q  <= instr_addr_F & 32'hFFFF_FFFC;
        wdata_q <= '0;
        be_q    <= BE_WORD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (grab)
      cnt <= '0;
    else if (busy)
      cnt <= cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)
      bus_error <= 1'b0;
    else if (timeout)
      bus_error <= 1'b1;
  end

  // A timed-out read returns zero so the requester never hangs.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_rdata_F <= '0;
      mem_out_M     <= '0;
    end else if (finish) begin
      if (state == ST_BUSY_I)
        instr_rdata_F <= rd;
      if ((state == ST_BUSY_D) && !we_q)
        mem_out_M <= rd;
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single unified memory port between instruction fetch (F stage) and the data access of the memory stage (M stage). Each access is a multi-cycle transaction with a ready handshake on the memory side. The arbiter stalls whichever requester is waiting and returns its read data in a registered output. It sits between the fetch/mem-stage datapath and the external memory model. The M-stage byte-lane logic already produces the store data and byte enables it passes through.

## Interface
- TIMEOUT, 16: max cycles to wait for `mem_ready` before aborting with an error.
- CW, 5: width of the timeout counter; must satisfy 2^CW > TIMEOUT.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- instr_req_F  in  1  fetch wants a word; held until stall drops.
- instr_addr_F  in  32  fetch address; bits [1:0] are ignored and driven to 0 on `mem_addr`.
- instr_rdata_F  out  32  fetched word, registered.
- instr_stall_F  out  1  fetch must hold.
- data_req_M  in  1  M-stage access request; held until stall drops.
- mem_write_M  in  1  1 = store, 0 = load; qualified by `data_req_M`.
- data_addr_M  in  32  data address; passed through unchanged.
- mem_in_M  in  32  store data, already lane-replicated.
- byte_en_M  in  4  store byte enables.
- mem_out_M  out  32  loaded word, registered; feeds sub-word extract.
- data_stall_M  out  1  M stage must hold.
- mem_req  out  1  transaction active toward memory.
- mem_we  out  1  write strobe.
- mem_addr  out  32  address.
- mem_wdata  out  32  write data.
- mem_be  out  4  byte enables; forced to 4'b1111 for reads.
- mem_rdata  in  32  read data; valid when `mem_ready` is high.
- mem_ready  in  1  one-cycle completion pulse.
- bus_error  out  1  sticky timeout flag; cleared only by reset.

## Operation
- State machine: IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.
- **IDLE:** grant a request.
  - If both requests are pending, data wins unless the last grant was data (`last_d`=1); then fetch wins.
  - Alternating on conflict this way prevents starvation.
  - On a grant, capture address, write data, `byte_en`, and the `we` command into registers. Go to BUSY_I or BUSY_D.
  - With no request, stay in IDLE.
- **BUSY_x:**
  - `mem_req`=1 and the `mem_*` outputs are driven from the captured registers.
  - On `mem_ready`=1: latch `mem_rdata` into `instr_rdata_F` or `mem_out_M` (loads only; stores leave `mem_out_M` unchanged). Update `last_d` and go to DONE_x.
  - The timeout counter increments each BUSY cycle. When it reaches TIMEOUT without `mem_ready`:
    - set `bus_error`;
    - load all-zero read data;
    - go to DONE_x (the requester is released, never hung).
- **DONE_x:** one cycle with that requester's stall low; then IDLE. `mem_req`=0.
- **Stall outputs:**
  - `instr_stall_F` = `instr_req_F` & ~(state==DONE_I).
  - `data_stall_M` = `data_req_M` & ~(state==DONE_D).
  - Both are combinational from the registered state and the inputs.
- A request withdrawn while in BUSY does not cancel the memory transaction; it completes and its data is discarded.
- A `mem_ready` pulse outside BUSY is ignored.

## Timing
- Reset values:
  - state=IDLE, `last_d`=0, counter=0, `bus_error`=0.
  - `instr_rdata_F`=0, `mem_out_M`=0.
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `mem_be`=0.
- Minimum access: request seen in IDLE at cycle 0. `mem_req` is high in cycle 1; with `mem_ready` also in cycle 1, the state is DONE in cycle 2 (stall low) and IDLE in cycle 3. That is 3 cycles per access.
- Each memory wait cycle adds one cycle.
- Read data is valid on the rdata output from the DONE cycle onward and held until the next load by the same requester.
- Reset asserted mid-transaction: the arbiter returns to reset values on the next edge and the transaction is abandoned. The memory model must tolerate a dropped `mem_req`.
- The counter resets on every grant.

## Structure
- The shared package (`mem_defs.vh`) holds:
  - state encodings (3-bit localparams ST_IDLE … ST_DONE_D);
  - the BE_WORD=4'b1111 constant.
- One natural sub-module is `rr2`, a 2-way arbiter with a `last_d` register, updated only on a BUSY→DONE transition.
- Reuse the existing `flopenr` for the captured command registers.

## Test plan
- **Fetch only:** `instr_req_F`=1, addr 0x00400004, `mem_ready` in the first BUSY cycle returning 0x8C020000. Required: stall high for 2 cycles, `instr_rdata_F`=0x8C020000 in the DONE cycle, `mem_addr`=0x00400004.
- **Conflict:** both requests pending from reset. Required grant order: data, fetch, data. Each stall drops exactly once per grant.
- **Byte store:** data_addr 0x10010002, `mem_in_M`=0x5A5A5A5A, `byte_en_M`=4'b0100, write. Required: `mem_we`=1, `mem_be`=4'b0100; `mem_out_M` unchanged.
- **Wait states:** `mem_ready` delayed 5 cycles. Required: stall high for 6 cycles, then low for exactly 1.
- **Timeout:** `mem_ready` never asserted. Required: at cycle TIMEOUT in BUSY, `bus_error`=1, `mem_out_M`=0, stall released; `bus_error` still 1 on later accesses.
- **Reset mid-BUSY:** all outputs return to reset values on the next edge; the next request is serviced normally.
